// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the pipeline control unit.
//   - ctrl_op encodings carried down the pipe to MEM/WB
//   - exception codes (0 = none)
//   - control-register indices
//   - exe_mode constants and the EPC helper
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_WRCR = 2'd1,
        CTRL_OP_EXRT = 2'd2,
        CTRL_OP_RSVD = 2'd3
    } ctrl_op_e;

    localparam logic [2:0] EXP_NONE       = 3'd0;
    localparam logic [2:0] EXP_EXT_INT    = 3'd1;
    localparam logic [2:0] EXP_UNDEF      = 3'd2;
    localparam logic [2:0] EXP_OVF        = 3'd3;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;
    localparam logic [2:0] EXP_TRAP       = 3'd5;
    localparam logic [2:0] EXP_PRV_VIO    = 3'd6;

    localparam logic [4:0] CREG_STATUS     = 5'd0;
    localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
    localparam logic [4:0] CREG_PC         = 5'd2;
    localparam logic [4:0] CREG_INT_MASK   = 5'd3;
    localparam logic [4:0] CREG_INT_PEND   = 5'd4;
    localparam logic [4:0] CREG_EPC        = 5'd5;
    localparam logic [4:0] CREG_EXP_VECTOR = 5'd6;
    localparam logic [4:0] CREG_CAUSE      = 5'd7;

    localparam logic EXE_MODE_KERNEL = 1'b0;
    localparam logic EXE_MODE_USER   = 1'b1;

    // An instruction faulting in a delay slot must restart at its branch,
    // which is the word before it.
    function automatic logic [29:0] exp_epc(input logic [29:0] pc, input logic br_flag);
        return br_flag ? (pc - 30'd1) : pc;
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: MEM/WB retire bus into the control unit.
//   master - driven by the MEM/WB pipeline register
//   slave  - consumed by cpu_ctrl
//   mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_exp_code, mem_out
interface cpu_ctrl_if;
    logic [29:0] mem_pc;
    logic        mem_en;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    modport master (
        output mem_pc, mem_en, mem_br_flag, mem_ctrl_op,
               mem_dst_addr, mem_exp_code, mem_out
    );

    modport slave (
        input  mem_pc, mem_en, mem_br_flag, mem_ctrl_op,
               mem_dst_addr, mem_exp_code, mem_out
    );
endinterface

// File: rtl/cpu_ctrl_creg_file.sv
// creg_file: control-register storage, read mux and field masking.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   exp_commit          - exception retires this edge (highest priority)
//   exrt_commit         - exception return retires this edge
//   wr_en/addr/data     - WRCR commit
//   mem_pc, mem_br_flag, mem_exp_code - retiring instruction context
//   irq                 - raw interrupt lines (INT_PEND)
//   rd_addr/rd_data     - combinational decode-stage read port
//   int_en, exe_mode, int_mask, epc, exp_vector - live register fields
module creg_file
    import cpu_ctrl_pkg::*;
#(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exp_commit,
    input  logic             exrt_commit,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [29:0]      mem_pc,
    input  logic             mem_br_flag,
    input  logic [2:0]       mem_exp_code,
    input  logic [IRQ_W-1:0] irq,
    input  logic [4:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic             int_en,
    output logic             exe_mode,
    output logic [IRQ_W-1:0] int_mask,
    output logic [29:0]      epc,
    output logic [29:0]      exp_vector
);

    // status bit 1 = exe_mode, bit 0 = int_en
    logic [1:0]       status_q,     status_d;
    logic [1:0]       pre_status_q, pre_status_d;
    logic [IRQ_W-1:0] int_mask_q,   int_mask_d;
    logic [29:0]      epc_q,        epc_d;
    logic [29:0]      exp_vector_q, exp_vector_d;
    logic [3:0]       cause_q,      cause_d;

    always_comb begin
        status_d     = status_q;
        pre_status_d = pre_status_q;
        int_mask_d   = int_mask_q;
        epc_d        = epc_q;
        exp_vector_d = exp_vector_q;
        cause_d      = cause_q;

        if (exp_commit) begin
            cause_d      = {mem_br_flag, mem_exp_code};
            epc_d        = exp_epc(mem_pc, mem_br_flag);
            pre_status_d = status_q;
            status_d     = {EXE_MODE_KERNEL, 1'b0};
        end else if (exrt_commit) begin
            status_d = pre_status_q;
        end else if (wr_en) begin
            case (wr_addr)
                CREG_STATUS:     status_d     = wr_data[1:0];
                CREG_PRE_STATUS: pre_status_d = wr_data[1:0];
                CREG_INT_MASK:   int_mask_d   = wr_data[IRQ_W-1:0];
                CREG_EPC:        epc_d        = wr_data[31:2];
                CREG_EXP_VECTOR: exp_vector_d = wr_data[31:2];
                CREG_CAUSE:      cause_d      = wr_data[3:0];
                default: ;   // PC, INT_PEND and unmapped indices ignore writes
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q     <= 2'b00;
            pre_status_q <= 2'b00;
            int_mask_q   <= '1;
            epc_q        <= '0;
            exp_vector_q <= '0;
            cause_q      <= '0;
        end else begin
            status_q     <= status_d;
            pre_status_q <= pre_status_d;
            int_mask_q   <= int_mask_d;
            epc_q        <= epc_d;
            exp_vector_q <= exp_vector_d;
            cause_q      <= cause_d;
        end
    end

    // Reads return pre-commit values; decode is flushed on every commit anyway.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CREG_STATUS:     rd_data[1:0]       = status_q;
            CREG_PRE_STATUS: rd_data[1:0]       = pre_status_q;
            CREG_PC:         rd_data[31:2]      = mem_pc;
            CREG_INT_MASK:   rd_data[IRQ_W-1:0] = int_mask_q;
            CREG_INT_PEND:   rd_data[IRQ_W-1:0] = irq;
            CREG_EPC:        rd_data[31:2]      = epc_q;
            CREG_EXP_VECTOR: rd_data[31:2]      = exp_vector_q;
            CREG_CAUSE:      rd_data[3:0]       = cause_q;
            default:         rd_data            = '0;
        endcase
    end

    assign int_en     = status_q[0];
    assign exe_mode   = status_q[1];
    assign int_mask   = int_mask_q;
    assign epc        = epc_q;
    assign exp_vector = exp_vector_q;

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: pipeline control unit at MEM/WB.
// Retires exceptions, exception returns and control-register writes,
// redirects fetch, and produces per-stage stall/flush and int_detect.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   mem (cpu_ctrl_if.slave)         - MEM/WB retire bus
//   creg_rd_addr / creg_rd_data     - decode-stage control-register read
//   irq                             - level-sensitive interrupt lines
//   if_busy, mem_busy, ld_hazard    - stall requests
//   *_stall, *_flush                - per-stage pipeline control
//   new_pc                          - redirect target, valid with if_flush
//   exe_mode                        - 0 kernel, 1 user
//   int_detect                      - registered pending unmasked interrupt
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter int          IRQ_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    cpu_ctrl_if.slave        mem,
    input  logic [4:0]       creg_rd_addr,
    output logic [31:0]      creg_rd_data,
    input  logic [IRQ_W-1:0] irq,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             ld_hazard,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic [29:0]      new_pc,
    output logic             exe_mode,
    output logic             int_detect
);

    ctrl_op_e         ctrl_op;
    logic             retire;
    logic             exp_commit;
    logic             exrt_commit;
    logic             wrcr_commit;
    logic             busy;
    logic             int_en;
    logic [IRQ_W-1:0] int_mask;
    logic [29:0]      epc;
    logic [29:0]      exp_vector;

    logic             flush_q,      flush_d;
    logic [29:0]      new_pc_q,     new_pc_d;
    logic             int_detect_q, int_detect_d;

    assign ctrl_op = ctrl_op_e'(mem.mem_ctrl_op);

    // Flush wins over stall so a redirect can never be held off.
    assign busy      = if_busy | mem_busy;
    assign if_stall  = ~flush_q & (busy | ld_hazard);
    assign id_stall  = ~flush_q & (busy | ld_hazard);
    assign ex_stall  = ~flush_q & busy;
    assign mem_stall = ~flush_q & busy;

    assign retire      = mem.mem_en & ~mem_stall;
    assign exp_commit  = retire & (mem.mem_exp_code != EXP_NONE);
    assign exrt_commit = retire & ~exp_commit & (ctrl_op == CTRL_OP_EXRT);
    assign wrcr_commit = retire & ~exp_commit & (ctrl_op == CTRL_OP_WRCR);

    creg_file #(
        .IRQ_W (IRQ_W)
    ) u_creg_file (
        .clk          (clk),
        .reset        (reset),
        .exp_commit   (exp_commit),
        .exrt_commit  (exrt_commit),
        .wr_en        (wrcr_commit),
        .wr_addr      (mem.mem_dst_addr),
        .wr_data      (mem.mem_out),
        .mem_pc       (mem.mem_pc),
        .mem_br_flag  (mem.mem_br_flag),
        .mem_exp_code (mem.mem_exp_code),
        .irq          (irq),
        .rd_addr      (creg_rd_addr),
        .rd_data      (creg_rd_data),
        .int_en       (int_en),
        .exe_mode     (exe_mode),
        .int_mask     (int_mask),
        .epc          (epc),
        .exp_vector   (exp_vector)
    );

    // WRCR redirects to the next instruction so younger instructions
    // re-fetch under the new control state.
    always_comb begin
        flush_d  = exp_commit | exrt_commit | wrcr_commit;
        new_pc_d = new_pc_q;
        if (exp_commit) begin
            new_pc_d = exp_vector;
        end else if (exrt_commit) begin
            new_pc_d = epc;
        end else if (wrcr_commit) begin
            new_pc_d = mem.mem_pc + 30'd1;
        end
        int_detect_d = int_en & (|(irq & ~int_mask));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_q      <= 1'b0;
            new_pc_q     <= RESET_VECTOR;
            int_detect_q <= 1'b0;
        end else begin
            flush_q      <= flush_d;
            new_pc_q     <= new_pc_d;
            int_detect_q <= int_detect_d;
        end
    end

    assign if_flush   = flush_q;
    assign id_flush   = flush_q;
    assign ex_flush   = flush_q;
    assign mem_flush  = flush_q;
    assign new_pc     = new_pc_q;
    assign int_detect = int_detect_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;
    import cpu_ctrl_pkg::*;

    localparam logic [29:0] RV = 30'h0000_0400;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic [7:0]  irq;
    logic        if_busy, mem_busy, ld_hazard;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0] new_pc;
    logic        exe_mode, int_detect;

    int errors = 0;
    int checks = 0;

    cpu_ctrl_if mem_if ();

    cpu_ctrl #(.RESET_VECTOR(RV), .IRQ_W(8)) dut (
        .clk(clk), .reset(reset), .mem(mem_if),
        .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
        .irq(irq), .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .new_pc(new_pc), .exe_mode(exe_mode), .int_detect(int_detect)
    );

    always #5 clk = ~clk;

    wire [3:0] flushes = {if_flush, id_flush, ex_flush, mem_flush};
    wire [3:0] stalls  = {if_stall, id_stall, ex_stall, mem_stall};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_creg(input logic [4:0] a, output logic [31:0] d);
        creg_rd_addr = a;
        #1;
        d = creg_rd_data;
    endtask

    // One-cycle retire; returns 1ns after the commit edge with mem_en dropped.
    task automatic retire(input logic [29:0] pc, input logic [1:0] op, input logic [4:0] dst,
                          input logic [2:0] code, input logic br, input logic [31:0] dat);
        mem_if.mem_pc       = pc;
        mem_if.mem_ctrl_op  = op;
        mem_if.mem_dst_addr = dst;
        mem_if.mem_exp_code = code;
        mem_if.mem_br_flag  = br;
        mem_if.mem_out      = dat;
        mem_if.mem_en       = 1'b1;
        tick();
        mem_if.mem_en       = 1'b0;
        mem_if.mem_ctrl_op  = 2'd0;
        mem_if.mem_exp_code = 3'd0;
        mem_if.mem_br_flag  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (new_pc !== RV) begin errors++; $display("FAIL rst_new_pc got=%h exp=%h", new_pc, RV); end
        checks++; if (flushes !== 4'b0000) begin errors++; $display("FAIL rst_flush got=%b exp=0000", flushes); end
        checks++; if (stalls !== 4'b0000) begin errors++; $display("FAIL rst_stall got=%b exp=0000", stalls); end
        checks++; if (int_detect !== 1'b0 || exe_mode !== 1'b0) begin errors++; $display("FAIL rst_mode got=%b%b exp=00", int_detect, exe_mode); end
        rd_creg(CREG_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got=%h exp=0", d); end
        rd_creg(CREG_INT_MASK, d);
        checks++; if (d !== 32'hFF) begin errors++; $display("FAIL rst_int_mask got=%h exp=ff", d); end
        rd_creg(CREG_CAUSE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_cause got=%h exp=0", d); end
        tick();
        checks++; if (flushes !== 4'b0000) begin errors++; $display("FAIL idle_flush got=%b exp=0000", flushes); end
    endtask

    task automatic test_exception();
        logic [31:0] d;
        retire(30'h10, 2'd1, CREG_EXP_VECTOR, 3'd0, 1'b0, 32'h0000_0400);
        checks++; if (new_pc !== 30'h11 || flushes !== 4'b1111) begin errors++; $display("FAIL wrcr_ev got=%h/%b exp=11/1111", new_pc, flushes); end
        retire(30'h12, 2'd1, CREG_STATUS, 3'd0, 1'b0, 32'h3);
        checks++; if (exe_mode !== 1'b1 || new_pc !== 30'h13) begin errors++; $display("FAIL wrcr_status got=%b/%h exp=1/13", exe_mode, new_pc); end
        retire(30'h40, 2'd0, 5'd0, 3'd3, 1'b1, 32'h0);
        checks++; if (flushes !== 4'b1111) begin errors++; $display("FAIL exc_flush got=%b exp=1111", flushes); end
        checks++; if (new_pc !== 30'h100) begin errors++; $display("FAIL exc_new_pc got=%h exp=100", new_pc); end
        checks++; if (exe_mode !== 1'b0) begin errors++; $display("FAIL exc_mode got=%b exp=0", exe_mode); end
        rd_creg(CREG_EPC, d);
        checks++; if (d !== 32'h0000_00FC) begin errors++; $display("FAIL exc_epc got=%h exp=fc", d); end
        rd_creg(CREG_CAUSE, d);
        checks++; if (d !== 32'hB) begin errors++; $display("FAIL exc_cause got=%h exp=b", d); end
        rd_creg(CREG_PRE_STATUS, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL exc_pre_status got=%h exp=3", d); end
        rd_creg(CREG_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL exc_status got=%h exp=0", d); end
        tick();
        checks++; if (flushes !== 4'b0000) begin errors++; $display("FAIL exc_flush_len got=%b exp=0000", flushes); end
    endtask

    task automatic test_exrt();
        retire(30'h50, 2'd2, 5'd0, 3'd0, 1'b0, 32'h0);
        checks++; if (new_pc !== 30'h3F || flushes !== 4'b1111) begin errors++; $display("FAIL exrt_redirect got=%h/%b exp=3f/1111", new_pc, flushes); end
        checks++; if (exe_mode !== 1'b1) begin errors++; $display("FAIL exrt_mode got=%b exp=1", exe_mode); end
        tick();
        checks++; if (flushes !== 4'b0000) begin errors++; $display("FAIL exrt_flush_len got=%b exp=0000", flushes); end
    endtask

    task automatic test_wrcr_irq();
        logic [31:0] d;
        irq = 8'h01;
        tick();
        checks++; if (int_detect !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", int_detect); end
        retire(30'h20, 2'd1, CREG_INT_MASK, 3'd0, 1'b0, 32'h0000_00FE);
        checks++; if (new_pc !== 30'h21) begin errors++; $display("FAIL mask_new_pc got=%h exp=21", new_pc); end
        checks++; if (int_detect !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", int_detect); end
        rd_creg(CREG_INT_MASK, d);
        checks++; if (d !== 32'hFE) begin errors++; $display("FAIL mask_val got=%h exp=fe", d); end
        tick();
        checks++; if (int_detect !== 1'b1) begin errors++; $display("FAIL irq_detect got=%b exp=1", int_detect); end
        mem_if.mem_pc = 30'h77;
        rd_creg(CREG_PC, d);
        checks++; if (d !== 32'h0000_01DC) begin errors++; $display("FAIL rd_pc got=%h exp=1dc", d); end
        rd_creg(CREG_INT_PEND, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rd_pend got=%h exp=1", d); end
        rd_creg(5'd9, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rd_unmapped got=%h exp=0", d); end
        irq = 8'h00;
    endtask

    task automatic test_no_retire();
        logic [31:0] d;
        mem_if.mem_pc = 30'h99;
        mem_if.mem_exp_code = 3'd5;
        mem_if.mem_en = 1'b0;
        tick();
        mem_if.mem_exp_code = 3'd0;
        checks++; if (flushes !== 4'b0000 || exe_mode !== 1'b1) begin errors++; $display("FAIL en0_exc got=%b/%b exp=0000/1", flushes, exe_mode); end
        rd_creg(CREG_CAUSE, d);
        checks++; if (d !== 32'hB) begin errors++; $display("FAIL en0_cause got=%h exp=b", d); end
        retire(30'h99, 2'd3, CREG_STATUS, 3'd0, 1'b0, 32'h0);
        checks++; if (flushes !== 4'b0000 || exe_mode !== 1'b1) begin errors++; $display("FAIL rsvd_op got=%b/%b exp=0000/1", flushes, exe_mode); end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        mem_busy = 1'b1;
        mem_if.mem_pc = 30'h60;
        mem_if.mem_exp_code = 3'd2;
        mem_if.mem_br_flag = 1'b0;
        mem_if.mem_en = 1'b1;
        #1;
        checks++; if (stalls !== 4'b1111) begin errors++; $display("FAIL busy_stalls got=%b exp=1111", stalls); end
        tick();
        checks++; if (flushes !== 4'b0000 || exe_mode !== 1'b1) begin errors++; $display("FAIL busy_hold got=%b/%b exp=0000/1", flushes, exe_mode); end
        rd_creg(CREG_CAUSE, d);
        checks++; if (d !== 32'hB) begin errors++; $display("FAIL busy_cause got=%h exp=b", d); end
        mem_busy = 1'b0;
        tick();
        mem_if.mem_en = 1'b0;
        mem_if.mem_exp_code = 3'd0;
        checks++; if (flushes !== 4'b1111 || new_pc !== 30'h100) begin errors++; $display("FAIL release_redirect got=%b/%h exp=1111/100", flushes, new_pc); end
        checks++; if (exe_mode !== 1'b0) begin errors++; $display("FAIL release_mode got=%b exp=0", exe_mode); end
        rd_creg(CREG_CAUSE, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL release_cause got=%h exp=2", d); end
        rd_creg(CREG_EPC, d);
        checks++; if (d !== 32'h0000_0180) begin errors++; $display("FAIL release_epc got=%h exp=180", d); end
        tick();
    endtask

    task automatic test_epc_wrap();
        logic [31:0] d;
        retire(30'h0, 2'd0, 5'd0, 3'd6, 1'b1, 32'h0);
        rd_creg(CREG_EPC, d);
        checks++; if (d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_epc got=%h exp=fffffffc", d); end
        rd_creg(CREG_CAUSE, d);
        checks++; if (d !== 32'hE) begin errors++; $display("FAIL wrap_cause got=%h exp=e", d); end
        tick();
    endtask

    task automatic test_ld_hazard();
        ld_hazard = 1'b1;
        #1;
        checks++; if (stalls !== 4'b1100) begin errors++; $display("FAIL ld_stalls got=%b exp=1100", stalls); end
        retire(30'h30, 2'd1, CREG_CAUSE, 3'd0, 1'b0, 32'h5);
        checks++; if (flushes !== 4'b1111 || stalls !== 4'b0000) begin errors++; $display("FAIL ld_flush_prio got=%b/%b exp=1111/0000", flushes, stalls); end
        checks++; if (new_pc !== 30'h31) begin errors++; $display("FAIL ld_new_pc got=%h exp=31", new_pc); end
        tick();
        checks++; if (flushes !== 4'b0000 || stalls !== 4'b1100) begin errors++; $display("FAIL ld_after got=%b/%b exp=0000/1100", flushes, stalls); end
        ld_hazard = 1'b0;
    endtask

    task automatic test_reset_mid_redirect();
        logic [31:0] d;
        retire(30'h70, 2'd1, CREG_INT_MASK, 3'd0, 1'b0, 32'h0);
        checks++; if (flushes !== 4'b1111) begin errors++; $display("FAIL mid_pre got=%b exp=1111", flushes); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (flushes !== 4'b0000 || new_pc !== RV) begin errors++; $display("FAIL mid_reset got=%b/%h exp=0000/%h", flushes, new_pc, RV); end
        rd_creg(CREG_INT_MASK, d);
        checks++; if (d !== 32'hFF) begin errors++; $display("FAIL mid_mask got=%h exp=ff", d); end
    endtask

    initial begin
        reset = 1'b1;
        creg_rd_addr = 5'd0;
        irq = 8'h00;
        if_busy = 1'b0;
        mem_busy = 1'b0;
        ld_hazard = 1'b0;
        mem_if.mem_pc = '0;
        mem_if.mem_en = 1'b0;
        mem_if.mem_br_flag = 1'b0;
        mem_if.mem_ctrl_op = 2'd0;
        mem_if.mem_dst_addr = 5'd0;
        mem_if.mem_exp_code = 3'd0;
        mem_if.mem_out = '0;
        test_reset();
        test_exception();
        test_exrt();
        test_wrcr_irq();
        test_no_retire();
        test_stall();
        test_epc_wrap();
        test_ld_hazard();
        test_reset_mid_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
